// File: rtl/register_write_arbiter_if.sv
// Bundle of requester-side and shared-register signals for the write arbiter.
// master drives requests and register read-back; slave is the arbiter.
interface register_write_arbiter_if #(
    parameter int N = 24,
    parameter int R = 4
);
    logic [R-1:0]   req;
    logic [R*N-1:0] req_data;
    logic [N-1:0]   RegOut;
    logic [N-1:0]   RegIn;
    logic           WriteEn;
    logic [R-1:0]   gnt;
    logic [R-1:0]   done;
    logic           busy;
    logic           wr_err;

    modport master (
        output req, req_data, RegOut,
        input  RegIn, WriteEn, gnt, done, busy, wr_err
    );

    modport slave (
        input  req, req_data, RegOut,
        output RegIn, WriteEn, gnt, done, busy, wr_err
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter granting four requesters write access to one shared
// register, with a read-back check one cycle after each write.
//
// state | meaning
// IDLE  | waiting for req; arbitrates from r_ptr on every edge
// WRITE | WriteEn high for one cycle with latched data, gnt held
// CHECK | compare RegOut against latched data, gnt held
// DONE  | one-cycle done pulse, advance r_ptr past the served requester
module register_write_arbiter #(
    parameter int N = 24,
    parameter int R = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    register_write_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   r_ptr;
    logic [1:0]   r_idx;
    logic [N-1:0] r_data;
    logic         r_write_en;
    logic [R-1:0] r_gnt;
    logic [R-1:0] r_done;
    logic         r_wr_err;

    logic [1:0]   w_cand;
    logic [1:0]   w_win_idx;
    logic         w_win_valid;
    logic [N-1:0] w_win_data;
    logic [R-1:0] w_win_onehot;

    // Scan from the farthest candidate back to r_ptr so the nearest set bit wins.
    always_comb begin
        w_cand      = r_ptr;
        w_win_idx   = r_ptr;
        w_win_valid = 1'b0;
        for (int k = R - 1; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k);
            if (bus.req[w_cand]) begin
                w_win_idx   = w_cand;
                w_win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_data   = '0;
        w_win_onehot = '0;
        for (int i = 0; i < R; i++) begin
            if (2'(i) == w_win_idx) begin
                w_win_data      = bus.req_data[i*N +: N];
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd0;
            r_idx      <= 2'd0;
            r_data     <= '0;
            r_write_en <= 1'b0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            r_done     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_idx      <= w_win_idx;
                        r_data     <= w_win_data;
                        r_write_en <= 1'b1;
                        r_gnt      <= w_win_onehot;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (bus.RegOut != r_data) begin
                        r_wr_err <= 1'b1;
                    end
                    r_done  <= r_gnt;
                    r_gnt   <= '0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ptr   <= r_idx + 2'd1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // r_data doubles as the RegIn hold register between writes.
    assign bus.RegIn   = r_data;
    assign bus.WriteEn = r_write_en;
    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.wr_err  = r_wr_err;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter with a simple external register
// model that can be overridden to inject read-back mismatches.
module tb_register_write_arbiter;

    localparam int N = 24;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [N-1:0] r_model;
    logic         force_en;
    logic [N-1:0] force_val;

    register_write_arbiter_if #(.N(N), .R(4)) bus_if ();

    register_write_arbiter #(.N(N), .R(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial r_model = '0;
    always @(posedge clk) begin
        if (bus_if.WriteEn) r_model <= bus_if.RegIn;
    end
    assign bus_if.RegOut = force_en ? force_val : r_model;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int i, input logic [N-1:0] v);
        bus_if.req_data[i*N +: N] = v;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        force_en  = 1'b0;
        force_val = '0;
        bus_if.req      = 4'b0000;
        bus_if.req_data = '0;
        cyc();
        cyc();
        chk("rst_regin",   32'(bus_if.RegIn),   32'h0);
        chk("rst_we",      32'(bus_if.WriteEn), 32'h0);
        chk("rst_gnt",     32'(bus_if.gnt),     32'h0);
        chk("rst_done",    32'(bus_if.done),    32'h0);
        chk("rst_busy",    32'(bus_if.busy),    32'h0);
        chk("rst_wr_err",  32'(bus_if.wr_err),  32'h0);
        rst = 1'b1;

        // single request from requester 2
        bus_if.req = 4'b0100;
        set_slice(2, 24'h11111);
        cyc();
        chk("single_we",    32'(bus_if.WriteEn), 32'h1);
        chk("single_regin", 32'(bus_if.RegIn),   32'h11111);
        chk("single_gnt",   32'(bus_if.gnt),     32'h4);
        chk("single_busy",  32'(bus_if.busy),    32'h1);
        bus_if.req = 4'b0000;
        cyc();
        chk("single_chk_we",  32'(bus_if.WriteEn), 32'h0);
        chk("single_chk_gnt", 32'(bus_if.gnt),     32'h4);
        chk("single_regout",  32'(bus_if.RegOut),  32'h11111);
        cyc();
        chk("single_done",    32'(bus_if.done),    32'h4);
        chk("single_done_gnt",32'(bus_if.gnt),     32'h0);
        chk("single_err",     32'(bus_if.wr_err),  32'h0);
        cyc();
        chk("single_idle_done", 32'(bus_if.done), 32'h0);
        chk("single_idle_busy", 32'(bus_if.busy), 32'h0);

        // wrap: pointer sits at 3, requesters 3 and 0 both asking
        bus_if.req = 4'b1001;
        set_slice(3, 24'h33333);
        set_slice(0, 24'h00ABC);
        cyc();
        chk("wrap_gnt_a",   32'(bus_if.gnt),   32'h8);
        chk("wrap_regin_a", 32'(bus_if.RegIn), 32'h33333);
        cyc();
        cyc();
        cyc();
        chk("wrap_gap_we", 32'(bus_if.WriteEn), 32'h0);
        cyc();
        chk("wrap_gnt_b",   32'(bus_if.gnt),     32'h1);
        chk("wrap_we_b",    32'(bus_if.WriteEn), 32'h1);
        chk("wrap_regin_b", 32'(bus_if.RegIn),   32'h00ABC);
        bus_if.req = 4'b0000;
        cyc();
        cyc();
        cyc();

        // reset so round-robin starts from requester 0
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_slice(i, 24'(i));
        bus_if.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            cyc();
            chk("rr_we",    32'(bus_if.WriteEn), 32'h1);
            chk("rr_gnt",   32'(bus_if.gnt),     32'(1 << (t % 4)));
            chk("rr_regin", 32'(bus_if.RegIn),   32'(t % 4));
            cyc();
            chk("rr_we_off1", 32'(bus_if.WriteEn), 32'h0);
            chk("rr_regout",  32'(bus_if.RegOut),  32'(t % 4));
            cyc();
            chk("rr_we_off2", 32'(bus_if.WriteEn), 32'h0);
            chk("rr_done",    32'(bus_if.done),    32'(1 << (t % 4)));
            cyc();
            chk("rr_we_off3", 32'(bus_if.WriteEn), 32'h0);
            chk("rr_idle",    32'(bus_if.busy),    32'h0);
        end
        bus_if.req = 4'b0000;
        cyc();
        chk("rr_stop_we", 32'(bus_if.WriteEn), 32'h0);

        // mid-flight data change on requester 1 (pointer now 1)
        bus_if.req = 4'b0010;
        set_slice(1, 24'hAAAAA);
        cyc();
        chk("mid_gnt",   32'(bus_if.gnt),   32'h2);
        chk("mid_regin", 32'(bus_if.RegIn), 32'hAAAAA);
        set_slice(1, 24'h44444);
        bus_if.req = 4'b0000;
        cyc();
        chk("mid_regout",    32'(bus_if.RegOut), 32'hAAAAA);
        chk("mid_regin_chk", 32'(bus_if.RegIn),  32'hAAAAA);
        cyc();
        chk("mid_done", 32'(bus_if.done),   32'h2);
        chk("mid_err",  32'(bus_if.wr_err), 32'h0);
        cyc();

        // read-back mismatch on requester 2
        bus_if.req = 4'b0100;
        set_slice(2, 24'h22222);
        cyc();
        chk("mm_regin", 32'(bus_if.RegIn), 32'h22222);
        bus_if.req = 4'b0000;
        force_en   = 1'b1;
        force_val  = 24'h77777;
        cyc();
        chk("mm_err_pre", 32'(bus_if.wr_err), 32'h0);
        cyc();
        chk("mm_err_set", 32'(bus_if.wr_err), 32'h1);
        force_en = 1'b0;
        cyc();
        chk("mm_err_hold", 32'(bus_if.wr_err), 32'h1);
        bus_if.req = 4'b1000;
        set_slice(3, 24'h33333);
        cyc();
        chk("mm_clean_gnt", 32'(bus_if.gnt), 32'h8);
        bus_if.req = 4'b0000;
        cyc();
        cyc();
        cyc();
        chk("mm_err_sticky", 32'(bus_if.wr_err), 32'h1);

        // reset during CHECK aborts the transaction
        bus_if.req = 4'b0100;
        cyc();
        chk("abort_gnt", 32'(bus_if.gnt), 32'h4);
        bus_if.req = 4'b0000;
        cyc();
        rst = 1'b0;
        cyc();
        chk("abort_regin", 32'(bus_if.RegIn),   32'h0);
        chk("abort_we",    32'(bus_if.WriteEn), 32'h0);
        chk("abort_gnt0",  32'(bus_if.gnt),     32'h0);
        chk("abort_done",  32'(bus_if.done),    32'h0);
        chk("abort_busy",  32'(bus_if.busy),    32'h0);
        chk("abort_err",   32'(bus_if.wr_err),  32'h0);
        rst = 1'b1;
        cyc();
        chk("abort_no_done", 32'(bus_if.done), 32'h0);
        bus_if.req = 4'b1100;
        cyc();
        chk("abort_restart_gnt", 32'(bus_if.gnt), 32'h4);
        bus_if.req = 4'b0000;
        cyc();
        cyc();
        chk("abort_restart_done", 32'(bus_if.done), 32'h4);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
